bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Cook-time countdown for the microwave controller. Holds a BCD time of M:SS (0:00 to 9:59). Counts down once per tick pulse while running and flags completion at 0:00. Sits between the keypad/load logic and the magnetron/beeper control, driven by the shared 1 Hz tick enable.

## Interface
Parameters:
- none (fixed ranges: minutes 0-9, second-tens 0-5, second-ones 0-9)

Ports:
- clock  input  1  system clock; all state changes on rising edge
- clear  input  1  asynchronous, active-high reset
- tick  input  1  one-cycle 1 Hz enable; sampled only on rising clock edges
- load  input  1  one-cycle pulse; capture min_in/sec_tens_in/sec_ones_in
- min_in  input  4  BCD minutes
- sec_tens_in  input  4  BCD tens of seconds
- sec_ones_in  input  4  BCD ones of seconds
- start  input  1  one-cycle pulse; begin or resume countdown
- stop  input  1  one-cycle pulse; pause, cancel, or acknowledge done
- min_out  output  4  current minutes, registered
- sec_tens_out  output  4  current tens of seconds, registered
- sec_ones_out  output  4  current ones of seconds, registered
- running  output  1  high exactly while in RUN
- done  output  1  high exactly while in DONE

## Operation
- States:
  - IDLE: reset state
  - RUN
  - PAUSE
  - DONE
- While clear is high:
  - state = IDLE
  - all digit outputs = 0
  - running = 0, done = 0
- Load:
  - Accepted in IDLE, PAUSE and DONE.
  - Ignored in RUN.
  - Out-of-range digits are clamped: min_in > 9 gives 9, sec_tens_in > 5 gives 5, sec_ones_in > 9 gives 9.
  - Load in PAUSE stays in PAUSE.
  - Load in DONE moves to IDLE and clears done.
- Start:
  - From IDLE or PAUSE with a nonzero count, go to RUN.
  - When the count is 0:00, start is ignored.
  - In RUN or DONE, start is ignored.
- Stop:
  - RUN: go to PAUSE; the count is held.
  - PAUSE: go to IDLE and zero the count.
  - DONE: go to IDLE; the count stays 0:00.
  - IDLE: no effect.
- Tick in RUN decrements by one second:
  - sec_ones > 0: decrement sec_ones.
  - Otherwise sec_ones = 9, and borrow from sec_tens.
  - sec_tens > 0: decrement sec_tens.
  - Otherwise sec_tens = 5, and borrow from min (decrement min).
  - A decrement that produces 0:00 moves RUN to DONE on the same edge.
- Tick in any state other than RUN is ignored. No wrap below 0:00 is possible.
- Priority within one cycle, highest first: clear > stop > load > start > tick.
  - stop+tick in RUN: go to PAUSE with no decrement.
  - load+start in IDLE: load only; stay in IDLE.
  - start+stop in PAUSE: go to IDLE and zero the count.
- Outputs come from registers only. There is no combinational path from any input to any output.

## Timing
- Start sampled at edge k: running = 1 after edge k.
  - A tick at edge k is not counted, because the state was still IDLE or PAUSE.
  - The first decrement occurs on the next tick at edge > k.
- Tick sampled at edge k in RUN: the new digits are visible after edge k (one-edge latency).
- Reaching 0:00: digits = 0, running = 0 and done = 1, all after the same edge.
- done stays high until stop, load or clear. It is never a single-cycle pulse.
- Load sampled at edge k: the clamped digits are visible after edge k.
- Clear asserted mid-RUN: outputs go to their reset values immediately, without waiting for a clock edge. The first edge after clear deasserts behaves as in IDLE.
- Run time from start to done is N ticks, where N is the loaded time in seconds; it does not depend on tick spacing.

## Test plan
- Reset: assert clear while in RUN at 1:23 -> outputs immediately 0:00, running = 0, done = 0, with no clock edge needed.
- Borrow chain: load 1:00, start, 1 tick -> 0:59. Continue to 60 ticks total -> 0:00 with done = 1 and running = 0 after the 60th tick edge.
- Clamp: load min = 12, sec_tens = 7, sec_ones = 15 -> outputs 9:59. Start, 1 tick -> 9:58.
- Pause/resume/cancel:
  - load 0:05, start, 2 ticks, stop -> 0:03 and PAUSE; 3 further ticks leave 0:03.
  - start, 3 ticks -> done.
  - Repeat to PAUSE, then stop again -> 0:00, IDLE, done = 0.
- Simultaneous events:
  - In RUN at 0:10, stop+tick in the same cycle -> PAUSE at 0:10.
  - In IDLE, load 0:02 + start in the same cycle -> IDLE at 0:02.
  - In RUN, a load pulse -> ignored.
- Zero-start and done acknowledge:
  - In IDLE at 0:00, start -> stays IDLE, running = 0.
  - In DONE, start -> ignored.
  - Stop -> IDLE with done = 0.
  - Load 0:01 in DONE -> IDLE at 0:01.

Source files
------------

// File: rtl/bcd_countdown_timer_if.sv
// Signal bundle between the keypad/load logic and the cook-time countdown.
// The master drives the control pulses and preset digits; the timer drives the count and status.
interface bcd_countdown_timer_if;
  logic       tick;
  logic       load;
  logic [3:0] min_in;
  logic [3:0] sec_tens_in;
  logic [3:0] sec_ones_in;
  logic       start;
  logic       stop;
  logic [3:0] min_out;
  logic [3:0] sec_tens_out;
  logic [3:0] sec_ones_out;
  logic       running;
  logic       done;

  modport master (
    output tick, load, min_in, sec_tens_in, sec_ones_in, start, stop,
    input  min_out, sec_tens_out, sec_ones_out, running, done
  );

  modport slave (
    input  tick, load, min_in, sec_tens_in, sec_ones_in, start, stop,
    output min_out, sec_tens_out, sec_ones_out, running, done
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Microwave cook-time countdown: BCD M:SS from 9:59 down to 0:00, one second per tick.
// Control priority within a cycle is stop > load > start > tick; all outputs are registers.
module bcd_countdown_timer (
  input  logic                  clock,
  input  logic                  clear,
  bcd_countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] value, input logic [3:0] limit);
    logic [3:0] result;
    if (value > limit) begin
      result = limit;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // One-second BCD decrement with borrow from ones into tens into minutes.
  function automatic logic [11:0] bcd_decrement(input logic [11:0] count);
    logic [3:0] mins;
    logic [3:0] tens;
    logic [3:0] ones;
    mins = count[11:8];
    tens = count[7:4];
    ones = count[3:0];
    if (ones != 4'd0) begin
      ones = ones - 4'd1;
    end else begin
      ones = 4'd9;
      if (tens != 4'd0) begin
        tens = tens - 4'd1;
      end else begin
        tens = 4'd5;
        mins = mins - 4'd1;
      end
    end
    return {mins, tens, ones};
  endfunction

  state_t      state_r;
  logic [3:0]  min_r;
  logic [3:0]  tens_r;
  logic [3:0]  ones_r;
  logic        running_r;
  logic        done_r;

  logic [11:0] load_val_s;
  logic [11:0] dec_s;
  logic        dec_zero_s;
  logic        nonzero_s;

  assign load_val_s = {clamp_digit(bus.min_in, 4'd9),
                       clamp_digit(bus.sec_tens_in, 4'd5),
                       clamp_digit(bus.sec_ones_in, 4'd9)};
  assign dec_s      = bcd_decrement({min_r, tens_r, ones_r});
  assign dec_zero_s = (dec_s == 12'h000);
  assign nonzero_s  = ({min_r, tens_r, ones_r} != 12'h000);

  // Control FSM; count and status flags are updated alongside the state.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r   <= ST_IDLE;
      min_r     <= 4'd0;
      tens_r    <= 4'd0;
      ones_r    <= 4'd0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.stop) begin
            state_r <= ST_IDLE;
          end else if (bus.load) begin
            {min_r, tens_r, ones_r} <= load_val_s;
          end else if (bus.start && nonzero_s) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_r   <= ST_PAUSE;
            running_r <= 1'b0;
          end else if (bus.tick) begin
            {min_r, tens_r, ones_r} <= dec_s;
            // Reaching 0:00 hands over to DONE on the very same edge.
            if (dec_zero_s) begin
              state_r   <= ST_DONE;
              running_r <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (bus.stop) begin
            state_r                 <= ST_IDLE;
            {min_r, tens_r, ones_r} <= 12'h000;
          end else if (bus.load) begin
            {min_r, tens_r, ones_r} <= load_val_s;
          end else if (bus.start && nonzero_s) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end else begin
            state_r <= ST_PAUSE;
          end
        end
        ST_DONE: begin
          if (bus.stop) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
          end else if (bus.load) begin
            {min_r, tens_r, ones_r} <= load_val_s;
            state_r                 <= ST_IDLE;
            done_r                  <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          running_r <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.min_out      = min_r;
  assign bus.sec_tens_out = tens_r;
  assign bus.sec_ones_out = ones_r;
  assign bus.running      = running_r;
  assign bus.done         = done_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: a seconds-based reference model pushes the
// expected {running, done, M, S10, S1} per cycle; the value is popped and compared after the edge.
module tb_bcd_countdown_timer;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic clock = 1'b0;
  logic clear;

  bcd_countdown_timer_if bus ();

  bcd_countdown_timer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int          compared   = 0;
  int          mismatched = 0;
  logic [13:0] exp_q[$];
  int          m_state;
  int          m_secs;

  task automatic check_eq(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got run=%b done=%b %h:%h%h, expected run=%b done=%b %h:%h%h",
               tag, obs[13], obs[12], obs[11:8], obs[7:4], obs[3:0],
               exp[13], exp[12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  function automatic logic [13:0] pack_exp(input int st, input int secs);
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       r;
    logic       d;
    m = 4'(secs / 60);
    t = 4'((secs % 60) / 10);
    o = 4'(secs % 10);
    r = (st == S_RUN);
    d = (st == S_DONE);
    return {r, d, m, t, o};
  endfunction

  function automatic logic [13:0] observed();
    return {bus.running, bus.done, bus.min_out, bus.sec_tens_out, bus.sec_ones_out};
  endfunction

  // Reference model keeps the time as a plain number of seconds.
  task automatic model_step(input logic t, input logic ld, input logic st, input logic sp,
                            input int m, input int tn, input int o);
    int mm;
    int tt;
    int oo;
    mm = (m > 9) ? 9 : m;
    tt = (tn > 5) ? 5 : tn;
    oo = (o > 9) ? 9 : o;
    if (sp) begin
      if (m_state == S_RUN) m_state = S_PAUSE;
      else if (m_state == S_PAUSE) begin m_state = S_IDLE; m_secs = 0; end
      else if (m_state == S_DONE) m_state = S_IDLE;
    end else if (ld && m_state != S_RUN) begin
      m_secs = mm * 60 + tt * 10 + oo;
      if (m_state == S_DONE) m_state = S_IDLE;
    end else if (st && (m_state == S_IDLE || m_state == S_PAUSE) && m_secs != 0) begin
      m_state = S_RUN;
    end else if (t && m_state == S_RUN) begin
      m_secs = m_secs - 1;
      if (m_secs == 0) m_state = S_DONE;
    end
  endtask

  task automatic cycle(input string tag, input logic t, input logic ld, input logic st,
                       input logic sp, input int m, input int tn, input int o);
    @(negedge clock);
    bus.tick        = t;
    bus.load        = ld;
    bus.start       = st;
    bus.stop        = sp;
    bus.min_in      = 4'(m);
    bus.sec_tens_in = 4'(tn);
    bus.sec_ones_in = 4'(o);
    model_step(t, ld, st, sp, m, tn, o);
    exp_q.push_back(pack_exp(m_state, m_secs));
    @(posedge clock);
    #1;
    bus.tick  = 1'b0;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_eq(tag, observed(), exp_q.pop_front());
  endtask

  task automatic do_tick(input string tag);  cycle(tag, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0); endtask
  task automatic do_idle(input string tag);  cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0); endtask
  task automatic do_start(input string tag); cycle(tag, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0); endtask
  task automatic do_stop(input string tag);  cycle(tag, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0); endtask
  task automatic do_load(input string tag, input int m, input int tn, input int o);
    cycle(tag, 1'b0, 1'b1, 1'b0, 1'b0, m, tn, o);
  endtask

  // Clear raised between edges must zero the outputs with no clock edge in between.
  task automatic mid_cycle_clear(input string tag);
    @(posedge clock);
    #3;
    clear   = 1'b1;
    m_state = S_IDLE;
    m_secs  = 0;
    exp_q.push_back(pack_exp(m_state, m_secs));
    #1;
    check_eq(tag, observed(), exp_q.pop_front());
    @(negedge clock);
    clear = 1'b0;
  endtask

  initial begin
    clear           = 1'b1;
    bus.tick        = 1'b0;
    bus.load        = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.min_in      = 4'd0;
    bus.sec_tens_in = 4'd0;
    bus.sec_ones_in = 4'd0;
    m_state         = S_IDLE;
    m_secs          = 0;

    #12;
    exp_q.push_back(pack_exp(m_state, m_secs));
    check_eq("reset", observed(), exp_q.pop_front());
    @(negedge clock);
    clear = 1'b0;

    do_load("rst_load", 1, 2, 3);
    do_start("rst_start");
    do_idle("rst_run");
    mid_cycle_clear("clear_mid_run");
    do_tick("after_clear");

    do_load("borrow_load", 1, 0, 0);
    do_start("borrow_start");
    for (int i = 1; i <= 60; i++) begin
      do_tick("borrow_tick");
      if (i % 7 == 0) do_idle("borrow_gap");
    end
    do_idle("done_hold");
    do_stop("done_ack");

    do_load("clamp_load", 12, 7, 15);
    do_start("clamp_start");
    do_tick("clamp_tick");
    do_stop("clamp_pause");
    do_stop("clamp_cancel");

    do_load("pr_load", 0, 0, 5);
    do_start("pr_start");
    do_tick("pr_tick");
    do_tick("pr_tick");
    do_stop("pr_pause");
    for (int i = 0; i < 3; i++) do_tick("pr_paused_tick");
    do_start("pr_resume");
    for (int i = 0; i < 3; i++) do_tick("pr_resume_tick");
    do_stop("pr_ack");
    do_load("pr2_load", 0, 0, 5);
    do_start("pr2_start");
    do_tick("pr2_tick");
    do_tick("pr2_tick");
    do_stop("pr2_pause");
    do_stop("pr2_cancel");
    do_start("zero_start");

    do_load("sim_load", 0, 1, 0);
    do_start("sim_start");
    cycle("stop_tick", 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    cycle("pause_start_stop", 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
    cycle("load_start_idle", 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 2);
    do_start("sim2_start");
    do_load("load_in_run", 0, 0, 7);
    cycle("load_tick_run", 1'b1, 1'b1, 1'b0, 1'b0, 0, 4, 4);
    do_tick("sim2_last_tick");
    do_start("start_in_done");
    do_stop("stop_in_done");
    do_start("zero_start2");

    do_load("done_load_prep", 0, 0, 1);
    do_start("done_load_start");
    do_tick("done_load_tick");
    do_load("load_in_done", 0, 0, 1);
    do_start("after_done_load");
    do_tick("final_tick");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
